vx_gbar_unit: RTL
=================

// Module: vx_gbar_unit
// PURPOSE
//  Global barrier responder: the far end of the per-socket gbar request bus.
//  Collects barrier arrivals from up to NUM_CORES cores per barrier id.
//  When the expected core count has arrived, broadcasts one release response and rearms that barrier.
//  Sits at cluster level, one instance per cluster, fed by the socket gbar arbiter outputs.
// PARAMETERS
//  NUM_BARRIERS  4  number of independent barrier ids; NB_WIDTH = `UP(`CLOG2(NUM_BARRIERS))
//  NUM_CORES     4  cores that can participate; NC_WIDTH = `UP(`CLOG2(NUM_CORES))
// PORTS
//  clk           in   1         clock
//  reset         in   1         asynchronous, active-low reset
//  req_valid     in   1         barrier arrival request
//  req_id        in   NB_WIDTH  barrier id
//  req_size_m1   in   NC_WIDTH  expected participating cores minus 1
//  req_core_id   in   NC_WIDTH  arriving core index
//  req_ready     out  1         request accepted (req_valid & req_ready)
//  rsp_valid     out  1         release broadcast; one-cycle pulse, no backpressure
//  rsp_id        out  NB_WIDTH  released barrier id
//  err_dup       out  1         sticky: a core arrived twice or core id >= NUM_CORES
//  err_size      out  1         sticky: size mismatch or size_m1 >= NUM_CORES
//  busy          out  1         some barrier holds at least one pending arrival
// BEHAVIOUR
//  Reset (asynchronous assert, synchronous release)
//   - All arrival masks = 0; stored sizes = 0.
//   - rsp_valid = 0, rsp_id = 0, err_dup = 0, err_size = 0, busy = 0. req_ready = 1.
//  State per id
//   - mask[id]: NUM_CORES-bit arrival mask.
//   - size_q[id]: NC_WIDTH bits, captured on the first arrival (mask[id] == 0).
//  req_ready is held at 1 outside reset; every accepted request updates state in one cycle.
//  Accepted request (id, size_m1, core):
//   a) core >= NUM_CORES: drop the request, set err_dup.
//   b) mask[id][core] == 1: duplicate; drop the request, set err_dup.
//   c) mask[id] == 0 and size_m1 >= NUM_CORES: drop the request, set err_size.
//   d) Otherwise:
//      - eff_size = (mask[id] == 0) ? size_m1 : size_q[id].
//      - If mask[id] != 0 and size_m1 != size_q[id]: set err_size; still count the arrival using size_q.
//      - cnt = popcount(mask[id] | onehot(core)), computed in NC_WIDTH+1 bits.
//      - cnt == eff_size+1: release. Next cycle rsp_valid = 1 and rsp_id = id; mask[id] clears to 0 in
//        the same edge, so the barrier is rearmed.
//      - Otherwise: mask[id] |= onehot(core) and size_q[id] = eff_size.
//  Latency: accept edge -> rsp_valid on the following cycle (registered output).
//  size_m1 == 0: releases on the first arrival, so a single-core barrier still gets 1-cycle latency.
//  Back-to-back releases (same or different ids) give consecutive rsp_valid pulses.
//  An arrival to id X in the cycle X's rsp_valid is high sees the cleared mask and starts a new epoch.
//  rsp_valid is low in any cycle without a release; rsp_id holds its last value.
//  busy = |(OR of all masks), registered from next-state.
//  Error flags stay set until reset; an error never blocks later requests.
//  Reset mid-barrier discards partial arrivals and emits no response.
// STRUCTURE
//  Shared package VX_gpu_pkg holds:
//   - the gbar width constants (NB_WIDTH, NC_WIDTH derived from `NUM_BARRIERS / `NUM_CORES);
//   - typedef gbar_req_t {id, size_m1, core_id} and gbar_rsp_t {id}.
//  One sub-module: the VX_popcount instance (width NUM_CORES) on the next mask.
//  Everything else is one flop array per id plus the output registers.
// TESTING
//  1) size_m1=3, cores 0,1,2,3 arrive at id 2 on consecutive cycles
//     -> rsp_valid pulses once, on the cycle after core 3, with rsp_id=2; busy drops to 0.
//  2) size_m1=0, core 1 arrives at id 0
//     -> rsp_valid=1 and rsp_id=0 on the next cycle; mask stays 0.
//  3) size_m1=1, core 0 arrives at id 1, then core 0 again, then core 2
//     -> err_dup=1 after the second request; release fires after core 2.
//  4) size_m1=2 first, then core 1 arrives at the same id with size_m1=1
//     -> err_size=1; no release until a third distinct core arrives.
//  5) Full barrier on id 3 (size 2, cores 0 then 1) interleaved with id 1 (size 2, cores 2 then 3)
//     -> two independent releases with correct ids, pulses in completion order.
//  6) Two of four cores arrive at id 0, then reset is asserted low for 1 cycle
//     -> after reset: busy=0 and no rsp; a fresh 4-core barrier on id 0 needs all 4 arrivals again.

Source files
------------

// File: rtl/vx_gbar_unit_pkg.sv
// Shared gbar widths and request/response types for the cluster-level barrier responder.
package vx_gbar_unit_pkg;

  localparam int GBAR_NUM_BARRIERS = 4;
  localparam int GBAR_NUM_CORES    = 4;

  localparam int NB_WIDTH = (GBAR_NUM_BARRIERS > 1) ? $clog2(GBAR_NUM_BARRIERS) : 1;
  localparam int NC_WIDTH = (GBAR_NUM_CORES > 1) ? $clog2(GBAR_NUM_CORES) : 1;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
    logic [NC_WIDTH-1:0] size_m1;
    logic [NC_WIDTH-1:0] core_id;
  } gbar_req_t;

  typedef struct packed {
    logic [NB_WIDTH-1:0] id;
  } gbar_rsp_t;

endpackage

// File: rtl/vx_gbar_unit_popcount.sv
// Population count of an arrival mask.
module vx_gbar_unit_popcount #(
  parameter int WIDTH = 4,
  parameter int OUT_W = 3
) (
  input  logic [WIDTH-1:0] bits,
  output logic [OUT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) cnt = cnt + OUT_W'(bits[i]);
  end

endmodule

// File: rtl/vx_gbar_unit.sv
// Global barrier responder: counts per-id core arrivals, broadcasts one release
// pulse when the expected count is reached and rearms that barrier.
module vx_gbar_unit
  import vx_gbar_unit_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [NB_WIDTH-1:0] req_id,
  input  logic [NC_WIDTH-1:0] req_size_m1,
  input  logic [NC_WIDTH-1:0] req_core_id,
  output logic                req_ready,
  output logic                rsp_valid,
  output logic [NB_WIDTH-1:0] rsp_id,
  output logic                err_dup,
  output logic                err_size,
  output logic                busy
);

  localparam int NUM_BARRIERS = GBAR_NUM_BARRIERS;
  localparam int NUM_CORES    = GBAR_NUM_CORES;
  localparam int CNT_W        = NC_WIDTH + 1;

  gbar_req_t req;
  gbar_rsp_t rsp_q;

  logic [NUM_BARRIERS-1:0][NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_BARRIERS-1:0][NC_WIDTH-1:0]  size_q, size_d;

  logic                 id_ok, core_ok, size_ok, first, dup, take, release_hit;
  logic                 err_dup_set, err_size_set, busy_d;
  logic [NUM_CORES-1:0] cur_mask, core_oh, new_mask;
  logic [NC_WIDTH-1:0]  cur_size, eff_size;
  logic [CNT_W-1:0]     cnt;

  assign req       = '{id: req_id, size_m1: req_size_m1, core_id: req_core_id};
  assign req_ready = 1'b1;
  assign rsp_id    = rsp_q.id;

  // Ids beyond NUM_BARRIERS (non-power-of-2 configs only) are silently dropped.
  assign id_ok   = {1'b0, req.id} < (NB_WIDTH+1)'(NUM_BARRIERS);
  assign core_ok = {1'b0, req.core_id} < CNT_W'(NUM_CORES);
  assign size_ok = {1'b0, req.size_m1} < CNT_W'(NUM_CORES);

  assign cur_mask = id_ok ? mask_q[req.id] : '0;
  assign cur_size = id_ok ? size_q[req.id] : '0;
  assign first    = (cur_mask == '0);
  assign core_oh  = core_ok ? (NUM_CORES'(1) << req.core_id) : '0;
  assign dup      = |(cur_mask & core_oh);
  assign eff_size = first ? req.size_m1 : cur_size;
  assign new_mask = cur_mask | core_oh;

  vx_gbar_unit_popcount #(
    .WIDTH (NUM_CORES),
    .OUT_W (CNT_W)
  ) u_popcount (
    .bits (new_mask),
    .cnt  (cnt)
  );

  // A size mismatch on a later arrival is flagged but still counted against the stored size.
  assign take         = req_valid && id_ok && core_ok && !dup && !(first && !size_ok);
  assign release_hit  = take && (cnt == CNT_W'(eff_size) + CNT_W'(1));
  assign err_dup_set  = req_valid && id_ok && (!core_ok || dup);
  assign err_size_set = req_valid && id_ok && core_ok && !dup &&
                        ((first && !size_ok) || (!first && req.size_m1 != cur_size));

  always_comb begin
    mask_d = mask_q;
    size_d = size_q;
    if (take) begin
      if (release_hit) begin
        mask_d[req.id] = '0;
      end else begin
        mask_d[req.id] = new_mask;
        size_d[req.id] = eff_size;
      end
    end
    busy_d = |mask_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_q    <= '0;
      size_q    <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      err_dup   <= 1'b0;
      err_size  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      size_q    <= size_d;
      busy      <= busy_d;
      rsp_valid <= release_hit;
      if (release_hit) rsp_q.id <= req.id;
      if (err_dup_set) err_dup <= 1'b1;
      if (err_size_set) err_size <= 1'b1;
    end
  end

endmodule
